mem_port_arbiter: RTL and testbench

- Multicycle sequencer that shares the single-port data memory between two requesters: the CPU memory stage (port 0, `cpu_*`) and the debug/program-loader port (port 1, `dbg_*`).
- Serialises accesses and steers byte lanes for `sb`/`lb`-style byte operations.
- Rejects malformed requests.
- Returns completion to each requester with a one-cycle `done` pulse, so the CPU control sequencer holds its memory phase until `cpu_done`.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_arb_pick.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and lane helpers for the data-memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  function automatic logic [3:0] lane_be(input logic byte_acc, input logic [1:0] lane);
    return byte_acc ? (4'b0001 << lane) : 4'b1111;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane);
    return {24'd0, word[{lane, 3'b000} +: 8]};
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester ports, memory bus and status of the port arbiter
interface mem_port_arbiter_if #(
  parameter int MEM_AW = 10
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_byte;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_done;
  logic              cpu_err;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_byte;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_done;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  // System side: requesters plus the memory itself.
  modport master (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err,
    output dbg_req, dbg_we, dbg_byte, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done, dbg_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err,
    input  dbg_req, dbg_we, dbg_byte, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done, dbg_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select; MEM_ARB_RR_EN adds a round-robin pointer, else CPU has fixed priority
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic grant_en,
  input  logic cpu_req,
  input  logic dbg_req,
  output logic win,
  output logic win_valid
);

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  // Reset leaves the pointer on DBG so the CPU takes the first tie.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant <= PORT_DBG;
    end else if (grant_en && win_valid) begin
      last_grant <= win;
    end
  end

  always_comb begin
    win_valid = cpu_req | dbg_req;
    if (cpu_req && dbg_req) begin
      win = ~last_grant;
    end else begin
      win = dbg_req ? PORT_DBG : PORT_CPU;
    end
  end
`else
  logic unused_pick;
  assign unused_pick = &{1'b0, Clk, Reset, grant_en};

  always_comb begin
    win_valid = cpu_req | dbg_req;
    win       = cpu_req ? PORT_CPU : (dbg_req ? PORT_DBG : PORT_CPU);
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - serialises CPU and debug accesses to the single-port data memory
// Tie-break policy selected by MEM_ARB_RR_EN (round-robin) or fixed CPU priority when undefined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_t  state;
  logic        grant_en;
  logic        win;
  logic        win_valid;
  logic        win_we;
  logic        win_byte;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        req_err;

  logic        lat_port;
  logic        lat_we;
  logic        lat_byte;
  logic [1:0]  lat_lane;
  logic        lat_err;
  logic        resp_rd;
  logic [31:0] resp_word;

  assign grant_en = (state == ST_IDLE);

  mem_arb_pick u_pick (
    .Clk       (Clk),
    .Reset     (Reset),
    .grant_en  (grant_en),
    .cpu_req   (bus.cpu_req),
    .dbg_req   (bus.dbg_req),
    .win       (win),
    .win_valid (win_valid)
  );

  assign win_we    = (win == PORT_DBG) ? bus.dbg_we    : bus.cpu_we;
  assign win_byte  = (win == PORT_DBG) ? bus.dbg_byte  : bus.cpu_byte;
  assign win_addr  = (win == PORT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
  assign win_wdata = (win == PORT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

  assign req_err = (!win_byte && (win_addr[1:0] != 2'b00)) ||
                   (win_addr[31:MEM_AW+2] != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.dbg_done  <= 1'b0;
      bus.dbg_err   <= 1'b0;
      lat_port      <= PORT_CPU;
      lat_we        <= 1'b0;
      lat_byte      <= 1'b0;
      lat_lane      <= 2'b00;
      lat_err       <= 1'b0;
      resp_rd       <= 1'b0;
    end else begin
      bus.mem_en   <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_be   <= 4'b0000;
      bus.cpu_done <= 1'b0;
      bus.cpu_err  <= 1'b0;
      bus.dbg_done <= 1'b0;
      bus.dbg_err  <= 1'b0;
      resp_rd      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            lat_port <= win;
            lat_we   <= win_we;
            lat_byte <= win_byte;
            lat_lane <= win_addr[1:0];
            lat_err  <= req_err;
            // Memory strobes are set here so they are registered during ACCESS.
            bus.mem_en    <= !req_err;
            bus.mem_we    <= win_we && !req_err;
            bus.mem_be    <= req_err ? 4'b0000 : lane_be(win_byte, win_addr[1:0]);
            bus.mem_addr  <= win_addr[MEM_AW+1:2];
            bus.mem_wdata <= win_byte ? {4{win_wdata[7:0]}} : win_wdata;
            bus.busy      <= 1'b1;
            state         <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          bus.cpu_done <= (lat_port == PORT_CPU);
          bus.dbg_done <= (lat_port == PORT_DBG);
          bus.cpu_err  <= (lat_port == PORT_CPU) && lat_err;
          bus.dbg_err  <= (lat_port == PORT_DBG) && lat_err;
          resp_rd      <= !lat_we && !lat_err;
          bus.busy     <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory data lands in RESP, so it is steered through registered selects only.
  assign resp_word     = lat_byte ? lane_extract(bus.mem_rdata, lat_lane) : bus.mem_rdata;
  assign bus.cpu_rdata = (resp_rd && (lat_port == PORT_CPU)) ? resp_word : 32'd0;
  assign bus.dbg_rdata = (resp_rd && (lat_port == PORT_DBG)) ? resp_word : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_fail;
  logic [31:0] mem [0:1023];
  logic grants [0:3];
  int   ng;
  int   n_cpu;
  int   n_dbg;

  mem_port_arbiter_if #(.MEM_AW(10)) bus ();

  mem_port_arbiter #(.MEM_AW(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous single-port memory with byte enables.
  always @(posedge Clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic port, input logic req, input logic we, input logic bt,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_byte = bt; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_byte = bt; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
  endtask

  // Starts at an IDLE-cycle negedge and returns at the next IDLE-cycle negedge.
  task automatic access(input string tag, input logic port, input logic we, input logic bt,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_en, input logic [31:0] exp_maddr, input logic [3:0] exp_be,
                        input logic [31:0] exp_mwdata, input logic exp_err, input logic [31:0] exp_rdata);
    drive(port, 1'b1, we, bt, addr, wdata);
    @(negedge Clk);
    chk({tag, ".busy_access"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, ".mem_en"}, {31'd0, bus.mem_en}, {31'd0, exp_en});
    if (exp_en) begin
      chk({tag, ".mem_we"}, {31'd0, bus.mem_we}, {31'd0, we});
      chk({tag, ".mem_addr"}, {22'd0, bus.mem_addr}, exp_maddr);
      chk({tag, ".mem_be"}, {28'd0, bus.mem_be}, {28'd0, exp_be});
      chk({tag, ".mem_wdata"}, bus.mem_wdata, exp_mwdata);
    end
    @(negedge Clk);
    chk({tag, ".done"}, {31'd0, port ? bus.dbg_done : bus.cpu_done}, 32'd1);
    chk({tag, ".other_done"}, {31'd0, port ? bus.cpu_done : bus.dbg_done}, 32'd0);
    chk({tag, ".err"}, {31'd0, port ? bus.dbg_err : bus.cpu_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, port ? bus.dbg_rdata : bus.cpu_rdata, exp_rdata);
    drive(port, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge Clk);
    chk({tag, ".done_clear"}, {31'd0, port ? bus.dbg_done : bus.cpu_done}, 32'd0);
    chk({tag, ".busy_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic abort_access(input string tag, input logic port);
    drive(port, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678);
    @(negedge Clk);
    chk({tag, ".mem_en"}, {31'd0, bus.mem_en}, 32'd1);
    Reset = 1'b1;
    drive(port, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge Clk);
    chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, ".mem_en_off"}, {31'd0, bus.mem_en}, 32'd0);
    chk({tag, ".no_done"}, {30'd0, bus.cpu_done, bus.dbg_done}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk({tag, ".no_done_later"}, {30'd0, bus.cpu_done, bus.dbg_done}, 32'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    Reset  = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.mem_ctl", {26'd0, bus.mem_en, bus.mem_we, bus.mem_be}, 32'd0);
    chk("rst.mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst.done_err", {28'd0, bus.cpu_done, bus.cpu_err, bus.dbg_done, bus.dbg_err}, 32'd0);
    chk("rst.rdata", bus.cpu_rdata | bus.dbg_rdata, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    access("cpu_ww",  1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'd4, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
    access("cpu_br1", 1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'd4, 4'b1000, 32'h0000_0000, 1'b0, 32'h0000_00DE);
    access("cpu_ww2", 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hAABB_CCDD, 1'b1, 32'd4, 4'b1111, 32'hAABB_CCDD, 1'b0, 32'h0);
    access("cpu_br2", 1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'd4, 4'b1000, 32'h0000_0000, 1'b0, 32'h0000_00AA);
    access("dbg_bw",  1'b1, 1'b1, 1'b1, 32'h0000_0011, 32'hFFFF_FF55, 1'b1, 32'd4, 4'b0010, 32'h5555_5555, 1'b0, 32'h0);
    access("cpu_wr",  1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'd4, 4'b1111, 32'h0000_0000, 1'b0, 32'hAABB_55DD);
    access("dbg_br",  1'b1, 1'b0, 1'b1, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'd4, 4'b0100, 32'h0000_0000, 1'b0, 32'h0000_00BB);
    access("cpu_mis", 1'b0, 1'b0, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b0, 32'd0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0);
    access("dbg_oor", 1'b1, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0077, 1'b0, 32'd0, 4'b0000, 32'h0000_0000, 1'b1, 32'h0);

    abort_access("abort_dbg", 1'b1);
    abort_access("abort_cpu", 1'b0);

    // Both ports request continuously for four back-to-back slots.
    ng    = 0;
    n_cpu = 0;
    n_dbg = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (bus.cpu_done) begin
        n_cpu++;
        if (ng < 4) grants[ng] = 1'b0;
        ng++;
      end
      if (bus.dbg_done) begin
        n_dbg++;
        if (ng < 4) grants[ng] = 1'b1;
        ng++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("tie.slots", ng, 32'd4);
    chk("tie.first", {31'd0, grants[0]}, 32'd0);
`ifdef MEM_ARB_RR_EN
    chk("tie.second", {31'd0, grants[1]}, 32'd1);
    chk("tie.third", {31'd0, grants[2]}, 32'd0);
    chk("tie.fourth", {31'd0, grants[3]}, 32'd1);
    chk("tie.dbg_count", n_dbg, 32'd2);
`else
    chk("tie.cpu_count", n_cpu, 32'd4);
    chk("tie.dbg_count", n_dbg, 32'd0);
`endif
    repeat (3) @(negedge Clk);
    chk("tie.idle", {31'd0, bus.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
